// File: rtl/apb_master_arb.sv
// apb_master_arb: two-requester round-robin APB master with a wait-state timeout.
module apb_master_arb #(
  parameter int unsigned ADDRESS_SIZE = 32,
  parameter int unsigned DATA_SIZE    = 32,
  parameter int unsigned TIMEOUT      = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [1:0]                req,
  input  logic [1:0]                req_write,
  input  logic [2*ADDRESS_SIZE-1:0] req_addr,
  input  logic [2*DATA_SIZE-1:0]    req_wdata,
  output logic [1:0]                done,
  output logic [DATA_SIZE-1:0]      rdata,
  output logic                      err,
  output logic                      busy,
  output logic                      psel,
  output logic                      penable,
  output logic                      pwrite,
  output logic [ADDRESS_SIZE-1:0]   paddr,
  output logic [DATA_SIZE-1:0]      pwdata,
  input  logic                      pready,
  input  logic                      pslverr,
  input  logic [DATA_SIZE-1:0]      prdata
);

  localparam int unsigned   CW  = (TIMEOUT == 0) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] TMO = CW'(TIMEOUT);

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    ACCESS
  } state_t;

  state_t                  state_q, state_d;
  logic                    psel_q, psel_d;
  logic                    penable_q, penable_d;
  logic                    pwrite_q, pwrite_d;
  logic [ADDRESS_SIZE-1:0] paddr_q, paddr_d;
  logic [DATA_SIZE-1:0]    pwdata_q, pwdata_d;
  logic [DATA_SIZE-1:0]    rdata_q, rdata_d;
  logic [1:0]              done_q, done_d;
  logic                    err_q, err_d;
  logic                    winner_q, winner_d;
  logic                    last_grant_q, last_grant_d;
  logic [CW-1:0]           tcnt_q, tcnt_d;

  logic [1:0]              eligible;
  logic                    grant_idx;
  logic [1:0]              winner_onehot;
  logic [CW-1:0]           tcnt_inc;

  // State and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      psel_q       <= 1'b0;
      penable_q    <= 1'b0;
      pwrite_q     <= 1'b0;
      paddr_q      <= '0;
      pwdata_q     <= '0;
      rdata_q      <= '0;
      done_q       <= '0;
      err_q        <= 1'b0;
      winner_q     <= 1'b0;
      last_grant_q <= 1'b1;
      tcnt_q       <= '0;
    end else begin
      state_q      <= state_d;
      psel_q       <= psel_d;
      penable_q    <= penable_d;
      pwrite_q     <= pwrite_d;
      paddr_q      <= paddr_d;
      pwdata_q     <= pwdata_d;
      rdata_q      <= rdata_d;
      done_q       <= done_d;
      err_q        <= err_d;
      winner_q     <= winner_d;
      last_grant_q <= last_grant_d;
      tcnt_q       <= tcnt_d;
    end
  end

  // Arbitration, FSM next state and next registered outputs.
  always_comb begin
    state_d      = state_q;
    psel_d       = psel_q;
    penable_d    = penable_q;
    pwrite_d     = pwrite_q;
    paddr_d      = paddr_q;
    pwdata_d     = pwdata_q;
    rdata_d      = rdata_q;
    done_d       = '0;
    err_d        = 1'b0;
    winner_d     = winner_q;
    last_grant_d = last_grant_q;
    tcnt_d       = tcnt_q;

    // A requester just completed is masked so a still-high req is not re-granted.
    eligible      = req & ~done_q;
    grant_idx     = (eligible == 2'b11) ? ~last_grant_q : eligible[1];
    winner_onehot = winner_q ? 2'b10 : 2'b01;
    tcnt_inc      = (tcnt_q == '1) ? tcnt_q : tcnt_q + CW'(1);

    case (state_q)
      IDLE: begin
        if (eligible != 2'b00) begin
          state_d      = SETUP;
          psel_d       = 1'b1;
          penable_d    = 1'b0;
          winner_d     = grant_idx;
          last_grant_d = grant_idx;
          tcnt_d       = '0;
          pwrite_d     = req_write[grant_idx];
          paddr_d      = grant_idx ? req_addr[ADDRESS_SIZE +: ADDRESS_SIZE]
                                   : req_addr[0 +: ADDRESS_SIZE];
          pwdata_d     = grant_idx ? req_wdata[DATA_SIZE +: DATA_SIZE]
                                   : req_wdata[0 +: DATA_SIZE];
        end
      end
      SETUP: begin
        state_d   = ACCESS;
        penable_d = 1'b1;
      end
      ACCESS: begin
        if (pready) begin
          state_d   = IDLE;
          psel_d    = 1'b0;
          penable_d = 1'b0;
          done_d    = winner_onehot;
          err_d     = pslverr;
          if (!pwrite_q) begin
            rdata_d = prdata;
          end
        end else begin
          tcnt_d = tcnt_inc;
          if ((TIMEOUT != 0) && (tcnt_inc == TMO)) begin
            state_d   = IDLE;
            psel_d    = 1'b0;
            penable_d = 1'b0;
            done_d    = winner_onehot;
            err_d     = 1'b1;
          end
        end
      end
      default: begin
        state_d   = IDLE;
        psel_d    = 1'b0;
        penable_d = 1'b0;
      end
    endcase
  end

  assign psel    = psel_q;
  assign busy    = psel_q;
  assign penable = penable_q;
  assign pwrite  = pwrite_q;
  assign paddr   = paddr_q;
  assign pwdata  = pwdata_q;
  assign rdata   = rdata_q;
  assign done    = done_q;
  assign err     = err_q;

endmodule

// File: tb/tb_apb_master_arb.sv
// Testbench for apb_master_arb: directed cycle table, corner sequences, random run vs model.
module tb_apb_master_arb;

  localparam int unsigned AW  = 32;
  localparam int unsigned DW  = 32;
  localparam int unsigned TMO = 4;

  localparam logic [31:0] A0 = 32'h0000_0401;
  localparam logic [31:0] A1 = 32'h0000_0802;
  localparam logic [31:0] W0 = 32'h1111_0000;
  localparam logic [31:0] W1 = 32'h2222_0000;

  logic            clk = 1'b0;
  logic            rst;
  logic [1:0]      req, req_write;
  logic [2*AW-1:0] req_addr;
  logic [2*DW-1:0] req_wdata;
  logic [1:0]      done;
  logic [DW-1:0]   rdata;
  logic            err, busy, psel, penable, pwrite;
  logic [AW-1:0]   paddr;
  logic [DW-1:0]   pwdata;
  logic            pready, pslverr;
  logic [DW-1:0]   prdata;

  apb_master_arb #(
    .ADDRESS_SIZE(AW),
    .DATA_SIZE   (DW),
    .TIMEOUT     (TMO)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .req      (req),
    .req_write(req_write),
    .req_addr (req_addr),
    .req_wdata(req_wdata),
    .done     (done),
    .rdata    (rdata),
    .err      (err),
    .busy     (busy),
    .psel     (psel),
    .penable  (penable),
    .pwrite   (pwrite),
    .paddr    (paddr),
    .pwdata   (pwdata),
    .pready   (pready),
    .pslverr  (pslverr),
    .prdata   (prdata)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endfunction

  // One row per cycle: inputs driven in that cycle, outputs expected in that cycle.
  typedef struct {
    logic [1:0]  rq;
    logic [1:0]  wr;
    logic        rdy;
    logic        se;
    logic [31:0] prd;
    logic        ps;
    logic        pe;
    logic        pw;
    logic [1:0]  dn;
    logic        er;
    logic [31:0] rd;
    logic [31:0] ea;
    logic [31:0] ew;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic [1:0] rq, input logic [1:0] wr, input logic rdy,
                              input logic se, input logic [31:0] prd, input logic ps,
                              input logic pe, input logic pw, input logic [1:0] dn,
                              input logic er, input logic [31:0] rd, input logic [31:0] ea,
                              input logic [31:0] ew);
    vec_t v;
    v.rq = rq; v.wr = wr; v.rdy = rdy; v.se = se; v.prd = prd;
    v.ps = ps; v.pe = pe; v.pw = pw; v.dn = dn; v.er = er; v.rd = rd; v.ea = ea; v.ew = ew;
    return v;
  endfunction

  task automatic do_reset();
    rst       = 1'b1;
    req       = '0;
    req_write = '0;
    pready    = 1'b0;
    pslverr   = 1'b0;
    prdata    = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  // Reference model state (cycle-number arithmetic over whole transfers).
  int unsigned cyc, tr_g, tr_end, tr_w;
  bit          tr_act, tr_who, tr_wr, last_grant;
  logic [1:0]  m_done, nd, elig, rq_v, linger;
  logic        m_err, ne, m_psel, m_pen, m_pwrite;
  logic [31:0] m_paddr, m_pwdata, m_rdata;

  initial begin
    req_addr  = {A1, A0};
    req_wdata = {W1, W0};
    do_reset();

    // Single read, masked re-grant, wait-state write with slverr, timeout read.
    tbl.push_back(mk(2'b01, 2'b00, 0, 0, 32'h0,         0, 0, 0, 2'b00, 0, 32'h0,         32'h0, 32'h0));
    tbl.push_back(mk(2'b01, 2'b00, 1, 1, 32'hFFFF_FFFF, 1, 0, 0, 2'b00, 0, 32'h0,         A0,    W0));
    tbl.push_back(mk(2'b01, 2'b00, 1, 0, 32'hA5A5_0001, 1, 1, 0, 2'b00, 0, 32'h0,         A0,    W0));
    tbl.push_back(mk(2'b01, 2'b00, 0, 0, 32'h0,         0, 0, 0, 2'b01, 0, 32'hA5A5_0001, A0,    W0));
    tbl.push_back(mk(2'b10, 2'b10, 1, 1, 32'h0,         0, 0, 0, 2'b00, 0, 32'hA5A5_0001, A0,    W0));
    tbl.push_back(mk(2'b10, 2'b10, 0, 0, 32'h0,         1, 0, 1, 2'b00, 0, 32'hA5A5_0001, A1,    W1));
    tbl.push_back(mk(2'b10, 2'b10, 0, 0, 32'h0,         1, 1, 1, 2'b00, 0, 32'hA5A5_0001, A1,    W1));
    tbl.push_back(mk(2'b10, 2'b10, 0, 0, 32'h0,         1, 1, 1, 2'b00, 0, 32'hA5A5_0001, A1,    W1));
    tbl.push_back(mk(2'b10, 2'b10, 0, 0, 32'h0,         1, 1, 1, 2'b00, 0, 32'hA5A5_0001, A1,    W1));
    tbl.push_back(mk(2'b10, 2'b10, 1, 1, 32'hDEAD_BEEF, 1, 1, 1, 2'b00, 0, 32'hA5A5_0001, A1,    W1));
    tbl.push_back(mk(2'b10, 2'b10, 0, 0, 32'h0,         0, 0, 1, 2'b10, 1, 32'hA5A5_0001, A1,    W1));
    tbl.push_back(mk(2'b01, 2'b00, 0, 0, 32'h0,         0, 0, 1, 2'b00, 0, 32'hA5A5_0001, A1,    W1));
    tbl.push_back(mk(2'b01, 2'b00, 0, 0, 32'h0,         1, 0, 0, 2'b00, 0, 32'hA5A5_0001, A0,    W0));
    tbl.push_back(mk(2'b01, 2'b00, 0, 0, 32'h1234_5678, 1, 1, 0, 2'b00, 0, 32'hA5A5_0001, A0,    W0));
    tbl.push_back(mk(2'b01, 2'b00, 0, 0, 32'h1234_5678, 1, 1, 0, 2'b00, 0, 32'hA5A5_0001, A0,    W0));
    tbl.push_back(mk(2'b01, 2'b00, 0, 0, 32'h1234_5678, 1, 1, 0, 2'b00, 0, 32'hA5A5_0001, A0,    W0));
    tbl.push_back(mk(2'b01, 2'b00, 0, 0, 32'h1234_5678, 1, 1, 0, 2'b00, 0, 32'hA5A5_0001, A0,    W0));
    tbl.push_back(mk(2'b01, 2'b00, 1, 0, 32'h0000_0055, 0, 0, 0, 2'b01, 1, 32'hA5A5_0001, A0,    W0));
    tbl.push_back(mk(2'b00, 2'b00, 0, 0, 32'h0,         0, 0, 0, 2'b00, 0, 32'hA5A5_0001, A0,    W0));

    for (int i = 0; i < tbl.size(); i++) begin
      @(negedge clk);
      chk($sformatf("t%0d_psel", i),    psel,    tbl[i].ps);
      chk($sformatf("t%0d_busy", i),    busy,    tbl[i].ps);
      chk($sformatf("t%0d_penable", i), penable, tbl[i].pe);
      chk($sformatf("t%0d_pwrite", i),  pwrite,  tbl[i].pw);
      chk($sformatf("t%0d_done", i),    done,    tbl[i].dn);
      chk($sformatf("t%0d_rdata", i),   rdata,   tbl[i].rd);
      chk($sformatf("t%0d_paddr", i),   paddr,   tbl[i].ea);
      chk($sformatf("t%0d_pwdata", i),  pwdata,  tbl[i].ew);
      if (tbl[i].dn != 2'b00 || i == 0) chk($sformatf("t%0d_err", i), err, tbl[i].er);
      req       = tbl[i].rq;
      req_write = tbl[i].wr;
      pready    = tbl[i].rdy;
      pslverr   = tbl[i].se;
      prdata    = tbl[i].prd;
    end

    // Contention: both requests held, grants alternate 0,1,0,... with one IDLE per transfer.
    do_reset();
    req    = 2'b11;
    pready = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      chk($sformatf("rr%0d_psel", k),    psel,    (k % 3) != 0);
      chk($sformatf("rr%0d_penable", k), penable, (k % 3) == 2);
      if (k % 3 == 1) chk($sformatf("rr%0d_paddr", k), paddr, ((k / 3) % 2 == 0) ? A0 : A1);
      if (k % 3 == 0) chk($sformatf("rr%0d_done", k), done, (((k / 3) - 1) % 2 == 0) ? 2'b01 : 2'b10);
      else            chk($sformatf("rr%0d_done", k), done, 2'b00);
    end

    // Reset asserted while waiting in ACCESS.
    do_reset();
    req    = 2'b01;
    pready = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_pre_psel", psel, 1'b1);
    chk("rst_pre_penable", penable, 1'b1);
    #1 rst = 1'b1;
    #1;
    chk("rst_async_psel", psel, 1'b0);
    chk("rst_async_penable", penable, 1'b0);
    chk("rst_async_busy", busy, 1'b0);
    chk("rst_async_done", done, 2'b00);
    @(negedge clk);
    rst    = 1'b0;
    req    = 2'b11;
    pready = 1'b1;
    @(negedge clk);
    chk("rst_after_done0", done, 2'b00);
    chk("rst_after_psel", psel, 1'b1);
    chk("rst_after_paddr", paddr, A0);
    @(negedge clk);
    chk("rst_after_done1", done, 2'b00);
    @(negedge clk);
    chk("rst_after_done2", done, 2'b01);

    // Randomized traffic against the transfer-level model.
    do_reset();
    cyc = 0; tr_act = 0; last_grant = 1'b1; tr_g = 0; tr_end = 0; tr_w = 0; tr_who = 0; tr_wr = 0;
    m_done = '0; m_err = 1'b0; m_psel = 1'b0; m_pen = 1'b0; m_pwrite = 1'b0;
    m_paddr = '0; m_pwdata = '0; m_rdata = '0; rq_v = '0; linger = '0;
    for (int n = 0; n < 3000; n++) begin
      @(negedge clk);
      chk("r_psel",    psel,    m_psel);
      chk("r_busy",    busy,    m_psel);
      chk("r_penable", penable, m_pen);
      chk("r_pwrite",  pwrite,  m_pwrite);
      chk("r_paddr",   paddr,   m_paddr);
      chk("r_pwdata",  pwdata,  m_pwdata);
      chk("r_done",    done,    m_done);
      chk("r_rdata",   rdata,   m_rdata);
      if (m_done != 2'b00) chk("r_err", err, m_err);

      // Requesters hold until done; sometimes keep req high through the done cycle.
      for (int i = 0; i < 2; i++) begin
        if (linger[i]) begin
          rq_v[i]   = 1'b0;
          linger[i] = 1'b0;
        end else if (rq_v[i] && m_done[i]) begin
          if ($urandom_range(0, 1) == 0) linger[i] = 1'b1;
          else                           rq_v[i]   = 1'b0;
        end else if (!rq_v[i] && $urandom_range(0, 2) == 0) begin
          rq_v[i] = 1'b1;
        end
      end
      req       = rq_v;
      req_write = 2'($urandom_range(0, 3));
      req_addr  = {$urandom, $urandom};
      req_wdata = {$urandom, $urandom};
      prdata    = $urandom;
      pslverr   = 1'($urandom_range(0, 1));
      if (tr_act && cyc >= tr_g + 2) pready = ((cyc - tr_g - 2) == tr_w);
      else                           pready = 1'($urandom_range(0, 1));

      nd = '0;
      ne = 1'b0;
      if (tr_act && cyc == tr_end) begin
        nd = tr_who ? 2'b10 : 2'b01;
        if (tr_w >= TMO) begin
          ne = 1'b1;
        end else begin
          ne = pslverr;
          if (!tr_wr) m_rdata = prdata;
        end
        tr_act = 0;
      end else if (!tr_act) begin
        elig = req & ~m_done;
        if (elig != 2'b00) begin
          if (elig == 2'b11) tr_who = !last_grant;
          else               tr_who = elig[1];
          last_grant = tr_who;
          tr_wr      = req_write[tr_who];
          m_pwrite   = tr_wr;
          m_paddr    = tr_who ? req_addr[63:32]  : req_addr[31:0];
          m_pwdata   = tr_who ? req_wdata[63:32] : req_wdata[31:0];
          tr_g       = cyc;
          tr_w       = $urandom_range(0, 6);
          tr_end     = cyc + 1 + ((tr_w >= TMO) ? TMO : tr_w + 1);
          tr_act     = 1;
        end
      end
      m_done = nd;
      m_err  = ne;
      m_psel = tr_act;
      m_pen  = tr_act && (cyc + 1 >= tr_g + 2);
      cyc++;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
